// File: rtl/sc_juntador_pkg.sv
// Shared definitions for the nibble-to-byte assembler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sc_juntador_pkg;

    localparam int NIBBLE_W = 4;
    localparam int COUNT_W  = 8;

    // Assembly state: waiting for the low nibble, waiting for the high
    // nibble, or holding a completed byte for the downstream.
    typedef enum logic [1:0] {
        LOW  = 2'b00,
        HIGH = 2'b01,
        FULL = 2'b10
    } state_t;

endpackage

// File: rtl/sc_juntador_counter.sv
// Wrapping event counter, advances by one on each enabled edge.
// Latency: count reflects an enabled edge immediately after that edge.
// Backpressure: none; enable is sampled every cycle.
//
// Ports: clk / rst_n (async active-low), en (count this edge),
//        count (current value, wraps from all-ones to zero).
module sc_juntador_counter
    import sc_juntador_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_juntador.sv
// Joins two 4-bit nibbles (low first) into one byte and counts delivered bytes.
// Latency: byte valid one cycle after the high-nibble transfer.
// Backpressure: nibble ready drops while a byte is held and downstream is not ready.
//
// Ports:
//   SC_JUNTADOR_CLOCK_50       clock, rising edge
//   SC_JUNTADOR_RESET_InLow    async active-low reset
//   SC_JUNTADOR_clear_InLow    sync active-low clear (drops partial/held byte)
//   SC_JUNTADOR_data_InBUS     nibble in, qualified by data_InValid
//   SC_JUNTADOR_data_OutReady  block accepts a nibble this cycle
//   SC_JUNTADOR_data_OutBUS    assembled byte, qualified by data_OutValid
//   SC_JUNTADOR_data_InReady   downstream accepts the byte this cycle
//   SC_JUNTADOR_count_OutBUS   number of bytes delivered, wraps at 256
module sc_juntador
    import sc_juntador_pkg::*;
#(
    // Only 8 is supported: the byte is exactly two nibbles.
    parameter int DATAWIDTH = 8
) (
    input  logic                 SC_JUNTADOR_CLOCK_50,
    input  logic                 SC_JUNTADOR_RESET_InLow,
    input  logic                 SC_JUNTADOR_clear_InLow,
    input  logic [NIBBLE_W-1:0]  SC_JUNTADOR_data_InBUS,
    input  logic                 SC_JUNTADOR_data_InValid,
    output logic                 SC_JUNTADOR_data_OutReady,
    output logic [DATAWIDTH-1:0] SC_JUNTADOR_data_OutBUS,
    output logic                 SC_JUNTADOR_data_OutValid,
    input  logic                 SC_JUNTADOR_data_InReady,
    output logic [COUNT_W-1:0]   SC_JUNTADOR_count_OutBUS
);

    state_t              state;
    logic [NIBBLE_W-1:0] low_nib;
    logic [DATAWIDTH-1:0] byte_dat;
    logic                byte_vld;
    // Held low through reset so ready stays low until the first edge after release.
    logic                run_en;

    logic nib_xfer;
    logic byte_xfer;

    // Ready passes downstream ready straight through while a byte is held, so
    // a new low nibble can enter on the same edge the held byte leaves.
    assign SC_JUNTADOR_data_OutReady = run_en
                                     & SC_JUNTADOR_clear_InLow
                                     & ((state != FULL) | SC_JUNTADOR_data_InReady);

    assign nib_xfer  = SC_JUNTADOR_data_InValid & SC_JUNTADOR_data_OutReady;
    // Clear wins over a simultaneous byte handoff, so the byte is neither
    // delivered nor counted on a clear edge.
    assign byte_xfer = byte_vld & SC_JUNTADOR_data_InReady & SC_JUNTADOR_clear_InLow;

    assign SC_JUNTADOR_data_OutBUS   = byte_dat;
    assign SC_JUNTADOR_data_OutValid = byte_vld;

    always_ff @(posedge SC_JUNTADOR_CLOCK_50 or negedge SC_JUNTADOR_RESET_InLow) begin
        if (!SC_JUNTADOR_RESET_InLow) begin
            state    <= LOW;
            low_nib  <= '0;
            byte_dat <= '0;
            byte_vld <= 1'b0;
            run_en   <= 1'b0;
        end else begin
            run_en <= 1'b1;
            if (!SC_JUNTADOR_clear_InLow) begin
                state    <= LOW;
                low_nib  <= '0;
                byte_dat <= '0;
                byte_vld <= 1'b0;
            end else begin
                case (state)
                    LOW: begin
                        if (nib_xfer) begin
                            low_nib <= SC_JUNTADOR_data_InBUS;
                            state   <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (nib_xfer) begin
                            byte_dat <= {SC_JUNTADOR_data_InBUS, low_nib};
                            byte_vld <= 1'b1;
                            state    <= FULL;
                        end
                    end
                    FULL: begin
                        // A nibble can only be accepted here when the byte is
                        // also leaving, so nib_xfer implies byte_xfer.
                        if (byte_xfer) begin
                            byte_vld <= 1'b0;
                            if (nib_xfer) begin
                                low_nib <= SC_JUNTADOR_data_InBUS;
                                state   <= HIGH;
                            end else begin
                                state <= LOW;
                            end
                        end
                    end
                    default: begin
                        state    <= LOW;
                        byte_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

    sc_juntador_counter #(
        .WIDTH (COUNT_W)
    ) u_counter (
        .clk   (SC_JUNTADOR_CLOCK_50),
        .rst_n (SC_JUNTADOR_RESET_InLow),
        .en    (byte_xfer),
        .count (SC_JUNTADOR_count_OutBUS)
    );

endmodule

// File: tb/tb_sc_juntador.sv
// Bench for the nibble-to-byte assembler: scoreboard of expected bytes,
// popped by a monitor at each downstream handoff.
// Latency/backpressure exercised through the scenario tasks below.
module tb_sc_juntador;

    logic       clk;
    logic       rst_n;
    logic       clr_n;
    logic [3:0] in_dat;
    logic       in_vld;
    logic       out_rdy;
    logic [7:0] out_dat;
    logic       out_vld;
    logic       in_rdy;
    logic [7:0] out_cnt;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_cnt  = 8'd0;
    logic [7:0] mon_exp;

    sc_juntador #(.DATAWIDTH(8)) dut (
        .SC_JUNTADOR_CLOCK_50      (clk),
        .SC_JUNTADOR_RESET_InLow   (rst_n),
        .SC_JUNTADOR_clear_InLow   (clr_n),
        .SC_JUNTADOR_data_InBUS    (in_dat),
        .SC_JUNTADOR_data_InValid  (in_vld),
        .SC_JUNTADOR_data_OutReady (out_rdy),
        .SC_JUNTADOR_data_OutBUS   (out_dat),
        .SC_JUNTADOR_data_OutValid (out_vld),
        .SC_JUNTADOR_data_InReady  (in_rdy),
        .SC_JUNTADOR_count_OutBUS  (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: a byte handoff happens on the next rising edge whenever these
    // inputs/outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && clr_n === 1'b1 && out_vld === 1'b1 && in_rdy === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL byte_unexpected got=%h expected=none", out_dat);
            end else begin
                mon_exp = sb.pop_front();
                if (out_dat !== mon_exp) begin
                    failures++;
                    $display("FAIL byte_data got=%h expected=%h", out_dat, mon_exp);
                end
            end
            checks++;
            if (out_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL count_at_handoff got=%0d expected=%0d", out_cnt, exp_cnt);
            end
            exp_cnt = exp_cnt + 8'd1;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_nib(input logic [3:0] n);
        bit ok;
        ok     = 1'b0;
        in_vld = 1'b1;
        in_dat = n;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (out_rdy === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL nibble_accept_timeout got=not_accepted expected=accepted nib=%h", n);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d_pending expected=0_pending", sb.size());
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b expected=0", out_vld); end
        if (out_dat !== 8'h00) begin failures++; $display("FAIL reset_dat got=%h expected=00", out_dat); end
        if (out_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%0d expected=0", out_cnt); end
        if (out_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b expected=0", out_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_rdy !== 1'b0) begin failures++; $display("FAIL rdy_before_edge got=%b expected=0", out_rdy); end
        @(posedge clk); #1;
        checks++;
        if (out_rdy !== 1'b1) begin failures++; $display("FAIL rdy_after_edge got=%b expected=1", out_rdy); end
        exp_cnt = 8'd0;
    endtask

    task automatic test_basic();
        in_rdy = 1'b0;
        sb.push_back(8'hA5);
        send_nib(4'h5);
        checks++;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL basic_vld_high got=%b expected=0", out_vld); end
        send_nib(4'hA);
        checks += 3;
        if (out_vld !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b expected=1", out_vld); end
        if (out_dat !== 8'hA5) begin failures++; $display("FAIL basic_dat got=%h expected=a5", out_dat); end
        if (out_rdy !== 1'b0) begin failures++; $display("FAIL basic_rdy_full got=%b expected=0", out_rdy); end
        in_rdy = 1'b1;
        drain();
        checks += 2;
        if (out_cnt !== 8'd1) begin failures++; $display("FAIL basic_cnt got=%0d expected=1", out_cnt); end
        if (out_vld !== 1'b0) begin failures++; $display("FAIL basic_vld_after got=%b expected=0", out_vld); end
    endtask

    task automatic test_hold();
        logic [7:0] c0;
        in_rdy = 1'b0;
        sb.push_back(8'h3C);
        send_nib(4'hC);
        send_nib(4'h3);
        c0 = exp_cnt;
        // Offer a nibble the block must ignore while it is not ready.
        in_vld = 1'b1;
        in_dat = 4'hE;
        repeat (5) begin
            @(negedge clk);
            checks += 4;
            if (out_dat !== 8'h3C) begin failures++; $display("FAIL hold_dat got=%h expected=3c", out_dat); end
            if (out_vld !== 1'b1) begin failures++; $display("FAIL hold_vld got=%b expected=1", out_vld); end
            if (out_rdy !== 1'b0) begin failures++; $display("FAIL hold_rdy got=%b expected=0", out_rdy); end
            if (out_cnt !== c0) begin failures++; $display("FAIL hold_cnt got=%0d expected=%0d", out_cnt, c0); end
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        in_rdy = 1'b1;
        drain();
        sb.push_back(8'h5A);
        send_nib(4'hA);
        send_nib(4'h5);
        drain();
    endtask

    task automatic test_back_to_back();
        int         c_start;
        logic [7:0] n0;
        in_rdy = 1'b1;
        n0 = exp_cnt;
        sb.push_back(8'h21);
        sb.push_back(8'h43);
        c_start = cyc;
        send_nib(4'h1);
        send_nib(4'h2);
        send_nib(4'h3);
        send_nib(4'h4);
        checks++;
        if (cyc - c_start !== 4) begin
            failures++;
            $display("FAIL b2b_cycles got=%0d expected=4", cyc - c_start);
        end
        drain();
        checks++;
        if (out_cnt !== n0 + 8'd2) begin
            failures++;
            $display("FAIL b2b_cnt got=%0d expected=%0d", out_cnt, n0 + 8'd2);
        end
    endtask

    task automatic test_clear();
        logic [7:0] c0;
        in_rdy = 1'b1;
        send_nib(4'h7);
        // Clear in HIGH together with an offered nibble: the nibble is refused.
        clr_n  = 1'b0;
        in_vld = 1'b1;
        in_dat = 4'h9;
        #1;
        checks++;
        if (out_rdy !== 1'b0) begin failures++; $display("FAIL clear_rdy got=%b expected=0", out_rdy); end
        @(posedge clk); #1;
        clr_n  = 1'b1;
        in_vld = 1'b0;
        sb.push_back(8'h21);
        send_nib(4'h1);
        send_nib(4'h2);
        drain();
        // Clear while a byte is held, with downstream ready on the same edge.
        in_rdy = 1'b0;
        send_nib(4'h4);
        send_nib(4'h4);
        checks++;
        if (out_vld !== 1'b1) begin failures++; $display("FAIL clear_full_vld got=%b expected=1", out_vld); end
        c0 = exp_cnt;
        clr_n  = 1'b0;
        in_rdy = 1'b1;
        @(posedge clk); #1;
        clr_n = 1'b1;
        checks += 2;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL clear_drop_vld got=%b expected=0", out_vld); end
        if (out_cnt !== c0) begin failures++; $display("FAIL clear_cnt got=%0d expected=%0d", out_cnt, c0); end
        sb.push_back(8'h6B);
        send_nib(4'hB);
        send_nib(4'h6);
        drain();
    endtask

    task automatic test_reset_full();
        in_rdy = 1'b0;
        send_nib(4'hF);
        send_nib(4'hF);
        checks++;
        if (out_dat !== 8'hFF || out_vld !== 1'b1) begin
            failures++;
            $display("FAIL rstfull_pre got=%h/%b expected=ff/1", out_dat, out_vld);
        end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL rstfull_vld got=%b expected=0", out_vld); end
        if (out_cnt !== 8'd0) begin failures++; $display("FAIL rstfull_cnt got=%0d expected=0", out_cnt); end
        if (out_rdy !== 1'b0) begin failures++; $display("FAIL rstfull_rdy got=%b expected=0", out_rdy); end
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_rdy = 1'b1;
        sb.push_back(8'h96);
        send_nib(4'h6);
        send_nib(4'h9);
        drain();
        checks++;
        if (out_cnt !== 8'd1) begin failures++; $display("FAIL rstfull_after_cnt got=%0d expected=1", out_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        rst_n = 1'b0;
        #1;
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_rdy = 1'b1;
        for (int i = 0; i < 255; i++) begin
            b = 8'($urandom_range(0, 255));
            sb.push_back(b);
            send_nib(b[3:0]);
            send_nib(b[7:4]);
        end
        drain();
        checks++;
        if (out_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d expected=255", out_cnt); end
        sb.push_back(8'hC3);
        send_nib(4'h3);
        send_nib(4'hC);
        drain();
        checks++;
        if (out_cnt !== 8'd0) begin failures++; $display("FAIL wrap_0 got=%0d expected=0", out_cnt); end
    endtask

    initial begin
        rst_n  = 1'b0;
        clr_n  = 1'b1;
        in_dat = 4'h0;
        in_vld = 1'b0;
        in_rdy = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_clear();
        test_reset_full();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sc_juntador.md
SC_JUNTADOR -- requirements
Module: sc_juntador

Interface
REQ-001 Parameter DATAWIDTH, default 8, output byte width; only 8 is supported, and each nibble is DATAWIDTH/2 = 4 bits.
REQ-002 SC_JUNTADOR_CLOCK_50  input  1  single clock; all state changes on its rising edge.
REQ-003 SC_JUNTADOR_RESET_InLow  input  1  reset, asynchronous assert, active-low.
REQ-004 SC_JUNTADOR_clear_InLow  input  1  synchronous clear, active-low.
REQ-005 SC_JUNTADOR_data_InBUS  input  4  nibble in.
REQ-006 SC_JUNTADOR_data_InValid  input  1  nibble in valid.
REQ-007 SC_JUNTADOR_data_OutReady  output  1  block can accept a nibble.
REQ-008 SC_JUNTADOR_data_OutBUS  output  DATAWIDTH  assembled byte.
REQ-009 SC_JUNTADOR_data_OutValid  output  1  byte valid.
REQ-010 SC_JUNTADOR_data_InReady  input  1  downstream accepts the byte.
REQ-011 SC_JUNTADOR_count_OutBUS  output  8  count of bytes delivered.

Function
REQ-012 A nibble transfer SHALL occur on a rising edge with data_InValid=1 and data_OutReady=1; a byte transfer SHALL occur on a rising edge with data_OutValid=1 and data_InReady=1.
REQ-013 The FSM SHALL have exactly the states LOW (awaiting low nibble), HIGH (awaiting high nibble), and FULL (byte held).
REQ-014 In LOW, a nibble transfer SHALL store the nibble as bits [3:0] and move to HIGH.
REQ-015 In HIGH, a nibble transfer SHALL form data_OutBUS = {nibble, stored_low} and move to FULL; data_OutValid SHALL rise the cycle after the second nibble transfer (latency 1).
REQ-016 In FULL, data_OutValid SHALL be 1, and data_OutBUS SHALL hold stable until a byte transfer.
REQ-017 data_OutReady SHALL be 1 in LOW and HIGH, and in FULL only when data_InReady=1 (combinational pass-through).
REQ-018 In FULL, a byte transfer without a nibble transfer SHALL move to LOW; simultaneous byte and nibble transfers SHALL store the nibble as the new low nibble and move to HIGH.
REQ-019 data_OutValid SHALL be 0 in LOW and HIGH.
REQ-020 count_OutBUS SHALL increment by 1 on each byte transfer and wrap from 255 to 0.
REQ-021 data_InValid while data_OutReady=0 SHALL have no effect; the upstream holds its data.
REQ-022 clear_InLow=0 SHALL, on the next edge, force LOW, discard any partial or held byte, and deassert data_OutValid.
REQ-023 clear SHALL override any simultaneous transfer, SHALL leave count_OutBUS unchanged, and SHALL force data_OutReady to 0 while clear_InLow=0.

Reset
REQ-024 While RESET_InLow=0, asynchronously: state=LOW, stored nibble=0, data_OutBUS=0, data_OutValid=0, count_OutBUS=0.
REQ-025 data_OutReady SHALL be 0 during reset and 1 on the first edge after release.
REQ-026 Reset mid-operation SHALL drop any partial or held byte, with no output transfer.

Structure
REQ-027 A shared package SHALL hold the state encoding (LOW=2'b00, HIGH=2'b01, FULL=2'b10) and the NIBBLE_W=4 constant.
REQ-028 One sub-module SHALL exist: sc_juntador_counter, an 8-bit wrapping counter with enable, async active-low reset, and no clear input.
REQ-029 The state register, nibble register, and output register SHALL reside in sc_juntador; the implementation SHALL contain no latches.

Verification
REQ-030 Nibbles 0x5 then 0xA with InReady=1 -> data_OutBUS=0xA5, OutValid high one cycle after the second nibble, count=1.
REQ-031 Back-to-back nibble stream 1,2,3,4 with InValid and InReady held high -> bytes 0x21 then 0x43, count=2, and no nibble lost in FULL.
REQ-032 Byte 0x3C held with InReady=0 for 5 cycles -> data_OutBUS stable at 0x3C, OutValid=1, OutReady=0, count unchanged.
REQ-033 clear_InLow=0 in HIGH after low nibble 0x7, then nibbles 0x1, 0x2 -> output 0x21, not 0x?7.
REQ-034 Reset asserted in FULL (byte 0xFF) -> OutValid=0 and count=0 immediately; after release the next byte forms correctly.
REQ-035 Deliver 256 bytes -> count wraps from 255 to 0.
